// File: rtl/bist_response_analyzer.sv
// Purpose: memory BIST response analyzer. It holds each read strobe from the
// BIST controller, together with the expected data bit and the address, in a
// delay line for the memory read latency. It then compares rd_data against the
// expected background word and accumulates a saturating error count. It also
// captures the address and data of the first failing read.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start           one-cycle pulse; clears results and arms the analyzer
//   read_en         read strobe from the BIST controller
//   data_bit        expected background bit for the current read
//   addr            address presented with read_en
//   rd_data         memory read data, valid RD_LAT cycles after read_en
//   test_end        one-cycle pulse; controller back in standby
//   done            high once the last outstanding compare has completed
//   fail            sticky mismatch flag
//   err_cnt         saturating count of mismatching reads
//   fail_addr       address of the first mismatch
//   fail_data       rd_data of the first mismatch
module bist_response_analyzer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              read_en,
    input  logic              data_bit,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              test_end,
    output logic              done,
    output logic              fail,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   drain_cnt;
    logic [RD_LAT-1:0]  pipe_vld;
    logic [RD_LAT-1:0]  pipe_bit;
    logic [ADDR_W-1:0]  pipe_addr [RD_LAT];

    logic               clear;
    logic               enq;
    logic               load_cnt;
    logic               err_hit;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start restarts from any state and wins over test_end
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (start)         state_nxt = S_RUN;
                else if (test_end) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (start)                        state_nxt = S_RUN;
                else if (drain_cnt == CNT_W'(1))  state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode: enqueue, drain load and compare enable
    always_comb begin
        clear    = start;
        enq      = 1'b0;
        load_cnt = 1'b0;
        err_hit  = 1'b0;
        if (!start) begin
            enq      = (state == S_RUN) && read_en;
            load_cnt = (state == S_RUN) && test_end;
            err_hit  = ((state == S_RUN) || (state == S_DRAIN))
                       && pipe_vld[RD_LAT-1]
                       && (rd_data != {DATA_W{pipe_bit[RD_LAT-1]}});
        end
    end

    // Drain counter: loaded on DRAIN entry, counts the remaining compare slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (load_cnt) begin
            drain_cnt <= CNT_W'(RD_LAT);
        end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    // Read delay line aligning each strobe with its returning rd_data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            pipe_bit <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) pipe_addr[i] <= '0;
        end else begin
            pipe_vld[0]  <= enq && !clear;
            pipe_bit[0]  <= data_bit;
            pipe_addr[0] <= addr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld[i]  <= pipe_vld[i-1] && !clear;
                pipe_bit[i]  <= pipe_bit[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    // Result registers: saturating count, first-failure capture, done flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            done <= (state_nxt == S_DONE);
            if (clear) begin
                fail      <= 1'b0;
                err_cnt   <= '0;
                fail_addr <= '0;
                fail_data <= '0;
            end else if (err_hit) begin
                if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= pipe_addr[RD_LAT-1];
                    fail_data <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: two instances (latency 1 / 8-bit count and
// latency 3 / 2-bit count) share the strobe stimulus. Each instance sees the
// rd_data of its own latency, and both are compared every cycle against a
// read-transaction reference model.
module tb_bist_response_analyzer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       read_en;
    logic       data_bit;
    logic [3:0] addr;
    logic       test_end;
    logic [7:0] rd_data1, rd_data3;
    logic       done1, fail1, done3, fail3;
    logic [7:0] err1;
    logic [1:0] err3;
    logic [3:0] fa1, fa3;
    logic [7:0] fd1, fd3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bist_response_analyzer u_dut1 (
        .clk(clk), .rst(rst), .start(start), .read_en(read_en),
        .data_bit(data_bit), .addr(addr), .rd_data(rd_data1),
        .test_end(test_end), .done(done1), .fail(fail1), .err_cnt(err1),
        .fail_addr(fa1), .fail_data(fd1)
    );

    bist_response_analyzer #(.RD_LAT(3), .ERR_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .read_en(read_en),
        .data_bit(data_bit), .addr(addr), .rd_data(rd_data3),
        .test_end(test_end), .done(done3), .fail(fail3), .err_cnt(err3),
        .fail_addr(fa3), .fail_data(fd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle stimulus history (what was read, and what the memory returned)
    logic       bit_h  [4096];
    logic [3:0] addr_h [4096];
    logic [7:0] word_h [4096];

    // Reference model, one slot per instance
    int         lat  [2] = '{1, 3};
    int         cmax [2] = '{255, 3};
    int         mode [2];          // 0 idle, 1 running, 2 draining, 3 finished
    int         rem  [2];
    bit         e_fail [2];
    int         e_cnt  [2];
    logic [3:0] e_fa   [2];
    logic [7:0] e_fd   [2];
    bit         enq [2][4096];     // read issued in that cycle is awaiting its compare

    task automatic model_reset(input int i);
        mode[i] = 0; rem[i] = 0; e_fail[i] = 0; e_cnt[i] = 0;
        e_fa[i] = '0; e_fd[i] = '0;
        for (int j = 0; j <= 4; j++) if (cyc - j >= 0) enq[i][cyc-j] = 0;
    endtask

    task automatic model_edge(input int i, input int c, input bit st, input bit re, input bit te);
        int l;
        int r;
        l = lat[i];
        if (!rst) begin
            model_reset(i);
            return;
        end
        if (st) begin
            model_reset(i);
            mode[i] = 1;
            return;
        end
        r = c - l;
        if ((mode[i] == 1 || mode[i] == 2) && r >= 0 && enq[i][r]) begin
            enq[i][r] = 0;
            if (word_h[r] != {8{bit_h[r]}}) begin
                if (e_cnt[i] < cmax[i]) e_cnt[i]++;
                if (!e_fail[i]) begin
                    e_fail[i] = 1; e_fa[i] = addr_h[r]; e_fd[i] = word_h[r];
                end
            end
        end
        if (mode[i] == 1) begin
            if (re) enq[i][c] = 1;
            if (te) begin mode[i] = 2; rem[i] = l; end
        end else if (mode[i] == 2) begin
            rem[i]--;
            if (rem[i] == 0) mode[i] = 3;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d1.done", 32'(done1), 32'(mode[0] == 3));
        chk("d1.fail", 32'(fail1), 32'(e_fail[0]));
        chk("d1.err_cnt", 32'(err1), 32'(e_cnt[0]));
        chk("d1.fail_addr", 32'(fa1), 32'(e_fa[0]));
        chk("d1.fail_data", 32'(fd1), 32'(e_fd[0]));
        chk("d3.done", 32'(done3), 32'(mode[1] == 3));
        chk("d3.fail", 32'(fail3), 32'(e_fail[1]));
        chk("d3.err_cnt", 32'(err3), 32'(e_cnt[1]));
        chk("d3.fail_addr", 32'(fa3), 32'(e_fa[1]));
        chk("d3.fail_data", 32'(fd3), 32'(e_fd[1]));
    endtask

    // One clock cycle: drive inputs, let the edge pass, update model, check
    task automatic step(input bit st, input bit re, input bit b, input logic [3:0] a,
                        input logic [7:0] m, input bit te);
        int c;
        c = cyc;
        bit_h[c]  = b;
        addr_h[c] = a;
        word_h[c] = {8{b}} ^ m;
        start = st; read_en = re; data_bit = b; addr = a; test_end = te;
        rd_data1 = (c >= 1) ? word_h[c-1] : 8'h00;
        rd_data3 = (c >= 3) ? word_h[c-3] : 8'h00;
        @(posedge clk);
        model_edge(0, c, st, re, te);
        model_edge(1, c, st, re, te);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 4'h0, 8'h00, 0);
    endtask

    initial begin
        rst = 1'b0; start = 0; read_en = 0; data_bit = 0; addr = '0;
        test_end = 0; rd_data1 = '0; rd_data3 = '0;
        model_reset(0); model_reset(1);
        #2;
        check_all();
        #1 rst = 1'b1;

        // Clean march: 32 zero-background reads, then 32 one-background reads
        step(1, 0, 0, 4'h0, 8'h00, 0);
        for (int k = 0; k < 64; k++) step(0, 1, k >= 32, 4'(k), 8'h00, 0);
        step(0, 0, 0, 4'h0, 8'h00, 1);
        idle(1);
        chk("march.done1", 32'(done1), 32'd1);
        chk("march.fail1", 32'(fail1), 32'd0);
        chk("march.err1", 32'(err1), 32'd0);
        chk("march.done3_early", 32'(done3), 32'd0);
        idle(2);
        chk("march.done3", 32'(done3), 32'd1);

        // Single fault at address 7
        step(1, 0, 0, 4'h0, 8'h00, 0);
        step(0, 1, 0, 4'h0, 8'h00, 0);
        step(0, 1, 0, 4'h7, 8'h10, 0);
        idle(1);
        chk("single.fail1", 32'(fail1), 32'd1);
        chk("single.err1", 32'(err1), 32'd1);
        chk("single.fa1", 32'(fa1), 32'h7);
        chk("single.fd1", 32'(fd1), 32'h10);
        chk("single.fail3_early", 32'(fail3), 32'd0);
        idle(2);
        chk("single.fa3", 32'(fa3), 32'h7);
        step(0, 0, 0, 4'h0, 8'h00, 1);
        idle(3);

        // Multiple faults: first at 3, then 9, then three more (saturates 2-bit count)
        step(1, 0, 0, 4'h0, 8'h00, 0);
        step(0, 1, 1, 4'h3, 8'h01, 0);
        step(0, 1, 0, 4'h5, 8'h00, 0);
        step(0, 1, 0, 4'h9, 8'h80, 0);
        step(0, 1, 0, 4'hA, 8'h0F, 0);
        step(0, 1, 0, 4'hB, 8'hF0, 0);
        step(0, 1, 0, 4'hC, 8'hFF, 0);
        idle(3);
        chk("multi.err1", 32'(err1), 32'd5);
        chk("multi.fa1", 32'(fa1), 32'h3);
        chk("multi.fd1", 32'(fd1), 32'hFE);
        chk("multi.err3_sat", 32'(err3), 32'h3);
        chk("multi.fa3", 32'(fa3), 32'h3);
        step(0, 0, 0, 4'h0, 8'h00, 1);
        idle(3);

        // Faulty read issued with test_end; reads during drain must be ignored
        step(1, 0, 0, 4'h0, 8'h00, 0);
        step(0, 1, 0, 4'h1, 8'h00, 0);
        step(0, 1, 0, 4'h2, 8'h00, 0);
        step(0, 1, 1, 4'h6, 8'h0F, 1);
        step(0, 1, 0, 4'hD, 8'h55, 0);
        chk("lat3.done1", 32'(done1), 32'd1);
        chk("lat3.err1", 32'(err1), 32'd1);
        step(0, 1, 0, 4'hE, 8'h66, 0);
        chk("lat3.err3_mid", 32'(err3), 32'd0);
        chk("lat3.done3_mid", 32'(done3), 32'd0);
        step(0, 1, 0, 4'hF, 8'h77, 0);
        chk("lat3.err3", 32'(err3), 32'd1);
        chk("lat3.done3", 32'(done3), 32'd1);
        chk("lat3.fd3", 32'(fd3), 32'hF0);
        idle(2);
        chk("lat3.err1_frozen", 32'(err1), 32'd1);

        // Restart from DONE with fail set, then start together with test_end
        step(1, 0, 0, 4'h0, 8'h00, 0);
        chk("restart.done1", 32'(done1), 32'd0);
        chk("restart.fail1", 32'(fail1), 32'd0);
        chk("restart.err3", 32'(err3), 32'd0);
        step(0, 1, 0, 4'h2, 8'h33, 0);
        step(0, 1, 0, 4'h4, 8'h01, 0);
        step(1, 0, 0, 4'h0, 8'h00, 1);
        chk("restart_te.err1", 32'(err1), 32'd0);
        chk("restart_te.fail1", 32'(fail1), 32'd0);
        step(0, 1, 1, 4'h8, 8'h80, 0);
        idle(3);
        chk("restart_te.err1_run", 32'(err1), 32'd1);
        chk("restart_te.fa3", 32'(fa3), 32'h8);
        chk("restart_te.done3", 32'(done3), 32'd0);
        step(0, 0, 0, 4'h0, 8'h00, 1);
        idle(3);

        // Asynchronous reset mid-run with five errors counted
        step(1, 0, 0, 4'h0, 8'h00, 0);
        for (int j = 1; j <= 5; j++) step(0, 1, 0, 4'(j), 8'h01, 0);
        idle(3);
        chk("areset.err1_pre", 32'(err1), 32'd5);
        step(0, 1, 1, 4'hE, 8'h02, 0);
        #2 rst = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        chk("areset.err1", 32'(err1), 32'd0);
        chk("areset.fail1", 32'(fail1), 32'd0);
        chk("areset.fa1", 32'(fa1), 32'd0);
        check_all();
        @(posedge clk); #1;
        idle(2);
        rst = 1'b1;
        for (int j = 0; j < 4; j++) step(0, 1, 0, 4'(j), 8'hFF, j == 2);
        idle(3);
        chk("areset.ignored_err1", 32'(err1), 32'd0);
        chk("areset.ignored_done1", 32'(done1), 32'd0);
        step(1, 0, 0, 4'h0, 8'h00, 0);
        step(0, 1, 0, 4'h9, 8'h04, 0);
        idle(3);
        chk("areset.rearmed_err1", 32'(err1), 32'd1);
        step(0, 0, 0, 4'h0, 8'h00, 1);
        idle(3);

        // Random traffic with occasional restarts and ends
        step(1, 0, 0, 4'h0, 8'h00, 0);
        for (int n = 0; n < 300; n++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            step($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
                 4'($urandom), m, $urandom_range(0, 24) == 0);
        end
        step(0, 0, 0, 4'h0, 8'h00, 1);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
